// File: rtl/sort_sequencer.sv
// -----------------------------------------------------------------------------
// sort_sequencer
//
// Sequences the bar-array sort engine of the VGA bubble-sort display. It loads
// the N_BARS-entry bar array with a pattern, then feeds the engine's step
// input in single-step (PAUSE) or free-running (RUN) mode. It also counts
// issued steps and executed swaps, and it holds DONE until the user acks.
//
// Optional feature macro: SORT_SEQ_FIXED_DATA_EN
//   defined     : LOAD writes a descending ramp ~(addr<<3); no LFSR, SEED unused
//   not defined : LOAD writes the 8-bit Galois LFSR sequence starting at SEED
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   start_pulse  (re)load array and begin (accepted in any state)
//   step_pulse   single step request while PAUSE
//   run_toggle   PAUSE <-> RUN
//   ack          leave DONE
//   rate         clocks between auto steps in RUN (0 behaves as 1)
//   eng_busy     engine cannot accept a step this cycle
//   eng_swap     engine performed a swap (pulse)
//   eng_done     engine reports the array sorted (level)
//   ld_we/ld_addr/ld_data  array write port used during LOAD
//   eng_step     one-cycle step command to the engine
//   state        IDLE=0 LOAD=1 PAUSE=2 RUN=3 DONE=4
//   step_count   steps issued, saturating
//   swap_count   swaps seen outside IDLE/LOAD, saturating
//   done         high while in DONE
// -----------------------------------------------------------------------------
module sort_sequencer #(
    parameter int         ADDR_W = 5,
    parameter int         DATA_W = 8,
    parameter int         RATE_W = 24,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_pulse,
    input  logic              step_pulse,
    input  logic              run_toggle,
    input  logic              ack,
    input  logic [RATE_W-1:0] rate,
    input  logic              eng_busy,
    input  logic              eng_swap,
    input  logic              eng_done,
    output logic              ld_we,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              eng_step,
    output logic [2:0]        state,
    output logic [15:0]       step_count,
    output logic [15:0]       swap_count,
    output logic              done
);

    localparam int N_BARS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PAUSE = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic                ld_we_reg, ld_we_next;
    logic [ADDR_W-1:0]   ld_addr_reg, ld_addr_next;
    logic [DATA_W-1:0]   ld_data_reg, ld_data_next;
    logic                eng_step_reg, eng_step_next;
    logic [15:0]         step_count_reg, step_count_next;
    logic [15:0]         swap_count_reg, swap_count_next;
    logic                done_reg, done_next;
    logic [RATE_W-1:0]   timer_reg, timer_next;
    logic                pending_reg, pending_next;
    logic [RATE_W-1:0]   rate_m1;
    logic                expire;
    logic                want_step;

`ifdef SORT_SEQ_FIXED_DATA_EN
    // Descending ramp: index shifted into the upper bits, then inverted.
    function automatic logic [DATA_W-1:0] ramp_value(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] wide;
        wide = DATA_W'(idx);
        return ~(wide << 3);
    endfunction
`else
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    function automatic logic [7:0] lfsr_advance(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    // Holds the value for the *next* write; the current write is in ld_data_reg.
    logic [7:0] lfsr_reg, lfsr_next;
`endif

    // Timer expires when it has counted rate-1, giving a step period of rate.
    assign rate_m1 = (rate == '0) ? '0 : rate - RATE_W'(1);
    assign expire  = (timer_reg >= rate_m1);

    always_comb begin
        state_next      = state_reg;
        ld_we_next      = 1'b0;
        ld_addr_next    = '0;
        ld_data_next    = '0;
        eng_step_next   = 1'b0;
        step_count_next = step_count_reg;
        swap_count_next = swap_count_reg;
        done_next       = 1'b0;
        timer_next      = timer_reg;
        pending_next    = pending_reg;
        want_step       = 1'b0;
`ifndef SORT_SEQ_FIXED_DATA_EN
        lfsr_next       = lfsr_reg;
`endif

        if (start_pulse) begin
            // Restart from any state; the first write goes out right away.
            state_next      = LOAD;
            ld_we_next      = 1'b1;
            ld_addr_next    = '0;
            step_count_next = '0;
            swap_count_next = '0;
            timer_next      = '0;
            pending_next    = 1'b0;
`ifdef SORT_SEQ_FIXED_DATA_EN
            ld_data_next    = ramp_value('0);
`else
            ld_data_next    = DATA_W'(SEED_EFF);
            lfsr_next       = lfsr_advance(SEED_EFF);
`endif
        end else begin
            case (state_reg)
                IDLE: ;
                LOAD: begin
                    if (ld_addr_reg == ADDR_W'(N_BARS - 1)) begin
                        state_next = PAUSE;
                    end else begin
                        ld_we_next   = 1'b1;
                        ld_addr_next = ld_addr_reg + ADDR_W'(1);
`ifdef SORT_SEQ_FIXED_DATA_EN
                        ld_data_next = ramp_value(ld_addr_reg + ADDR_W'(1));
`else
                        ld_data_next = DATA_W'(lfsr_reg);
                        lfsr_next    = lfsr_advance(lfsr_reg);
`endif
                    end
                end
                PAUSE: begin
                    if (eng_done) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else if (run_toggle) begin
                        state_next   = RUN;
                        timer_next   = '0;
                        pending_next = 1'b0;
                    end else if (step_pulse && !eng_busy) begin
                        eng_step_next = 1'b1;
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        state_next   = DONE;
                        done_next    = 1'b1;
                        timer_next   = '0;
                        pending_next = 1'b0;
                    end else if (run_toggle) begin
                        state_next   = PAUSE;
                        timer_next   = '0;
                        pending_next = 1'b0;
                    end else begin
                        timer_next = expire ? '0 : timer_reg + RATE_W'(1);
                        // An expiry can be issued in the same cycle it occurs;
                        // otherwise it waits as the single pending step.
                        want_step     = pending_reg || expire;
                        eng_step_next = want_step && !eng_busy;
                        pending_next  = want_step && eng_busy;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_next = IDLE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase

            if (eng_step_next && (step_count_reg != 16'hFFFF)) begin
                step_count_next = step_count_reg + 16'd1;
            end
            if (eng_swap && (state_reg != IDLE) && (state_reg != LOAD)
                    && (swap_count_reg != 16'hFFFF)) begin
                swap_count_next = swap_count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            ld_we_reg      <= 1'b0;
            ld_addr_reg    <= '0;
            ld_data_reg    <= '0;
            eng_step_reg   <= 1'b0;
            step_count_reg <= '0;
            swap_count_reg <= '0;
            done_reg       <= 1'b0;
            timer_reg      <= '0;
            pending_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ld_we_reg      <= ld_we_next;
            ld_addr_reg    <= ld_addr_next;
            ld_data_reg    <= ld_data_next;
            eng_step_reg   <= eng_step_next;
            step_count_reg <= step_count_next;
            swap_count_reg <= swap_count_next;
            done_reg       <= done_next;
            timer_reg      <= timer_next;
            pending_reg    <= pending_next;
        end
    end

`ifndef SORT_SEQ_FIXED_DATA_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= SEED_EFF;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end
`endif

    assign ld_we      = ld_we_reg;
    assign ld_addr    = ld_addr_reg;
    assign ld_data    = ld_data_reg;
    assign eng_step   = eng_step_reg;
    assign state      = state_reg;
    assign step_count = step_count_reg;
    assign swap_count = swap_count_reg;
    assign done       = done_reg;

endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Controller that sequences the bar-array sort engine of the VGA bubble-sort display. It loads the 32-entry bar array with a pseudo-random pattern and gates the engine's step input in two modes: single-step (PAUSE) or free-running at a programmable rate (RUN). It counts issued steps and executed swaps for the seven-segment readout, and holds DONE until the user acknowledges. It replaces direct button-to-engine wiring, and its inputs are the debounced single-cycle button pulses.

## Interface
- ADDR_W, 5: bar index width; N_BARS = 2**ADDR_W
- DATA_W, 8: bar height width
- RATE_W, 24: auto-step interval counter width
- SEED, 8'hA5: LFSR seed; 0 is replaced by 1

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state and outputs cleared
- start_pulse  in  1  one-cycle pulse: (re)load array and begin
- step_pulse  in  1  one-cycle pulse: single step while PAUSE
- run_toggle  in  1  one-cycle pulse: PAUSE<->RUN
- ack  in  1  one-cycle pulse: leave DONE
- rate  in  RATE_W  clocks between auto steps; 0 treated as 1
- eng_busy  in  1  engine cannot accept a step this cycle
- eng_swap  in  1  one-cycle pulse: engine performed a swap
- eng_done  in  1  engine reports array sorted (level)
- ld_we  out  1  array write enable
- ld_addr  out  ADDR_W  array write index
- ld_data  out  DATA_W  array write value
- eng_step  out  1  one-cycle step command to engine
- state  out  3  IDLE=0, LOAD=1, PAUSE=2, RUN=3, DONE=4
- step_count  out  16  steps issued, saturating
- swap_count  out  16  swaps seen, saturating
- done  out  1  high in DONE

## Operation
- IDLE: outputs idle. start_pulse -> LOAD.
- LOAD (from any state on start_pulse):
  - On entry: clear step_count, swap_count, the rate timer and the pending flag; set LFSR to SEED.
  - For N_BARS consecutive cycles: ld_we=1, ld_addr = 0..N_BARS-1, ld_data = LFSR value.
  - The LFSR advances after each write: lfsr = lsb ? (lfsr>>1)^8'hB8 : lfsr>>1.
  - After the write at N_BARS-1 -> PAUSE.
- PAUSE:
  - step_pulse with eng_busy=0 -> eng_step next cycle.
  - step_pulse with eng_busy=1 is dropped, not queued.
  - run_toggle -> RUN.
- RUN:
  - The timer counts clocks; at count ≥ rate-1 the pending flag sets and the timer restarts.
  - While pending and eng_busy=0: issue eng_step and clear pending.
  - At most one step is pending at a time.
  - run_toggle -> PAUSE and clears the timer and pending.
  - step_pulse is ignored.
- eng_done high in PAUSE or RUN -> DONE. It overrides any step or toggle that cycle, so no eng_step is issued.
- DONE: done=1, no steps issued. ack -> IDLE.
- Priority, highest first: reset, start_pulse, eng_done, run_toggle, step/timer.
  - start_pulse together with ack in DONE -> LOAD.
- Counters:
  - step_count increments on each eng_step.
  - swap_count increments on each eng_swap in any state except IDLE and LOAD.
  - Both saturate at 16'hFFFF.

## Timing
- Reset values: ld_we=0, ld_addr=0, ld_data=0, eng_step=0, state=IDLE, step_count=0, swap_count=0, done=0. LFSR=SEED, timer=0, pending=0.
- All outputs are registered.
- start_pulse at edge k:
  - state=LOAD after edge k.
  - First write (addr 0) presented in the cycle after edge k.
  - Last write presented after edge k+N_BARS-1.
  - state=PAUSE after edge k+N_BARS.
- step_pulse -> eng_step: 1 cycle, width exactly 1 cycle.
- RUN with rate=R and eng_busy=0: eng_step period is exactly R cycles; first step R cycles after entering RUN.
- eng_done -> state=DONE / done=1: 1 cycle.
- Reset during LOAD aborts the load; the array keeps partial contents and is not cleaned up.

## Configuration
- SORT_SEQ_FIXED_DATA_EN defined: LOAD writes a deterministic descending ramp, ld_data = ~(ld_addr<<3) truncated to DATA_W (255, 247, …, 7 for defaults). The LFSR is not instantiated and SEED is unused.
- Not defined: LOAD writes the LFSR sequence.

## Test plan
- Reset then start_pulse (SEED=A5): ld_we high for 32 cycles, addr 0..31, data A5, EA, 75, …; then state=2.
- PAUSE, step_pulse ×3 with eng_busy=0 -> three 1-cycle eng_step pulses, step_count=3; step_pulse with eng_busy=1 -> no eng_step, count unchanged.
- run_toggle, rate=4 -> eng_step every 4 cycles; eng_busy held 6 cycles across an expiry -> exactly one step, issued the cycle after busy drops.
- eng_done asserted in the same cycle as step_pulse -> no eng_step, state=4, done=1; ack -> state=0, done=0.
- start_pulse in RUN with step_count=10 -> counters 0, reload occurs; reset mid-LOAD at addr 12 -> all outputs at reset values next cycle.
- With SORT_SEQ_FIXED_DATA_EN: load writes FF, F7, …, 07; 70000 eng_swap pulses -> swap_count=FFFF.
